// File: rtl/mcu51_pkg.sv
// mcu51_pkg: shared SFR addresses, interrupt source indices and bit positions
package mcu51_pkg;
  localparam logic [7:0] ADDR_TCON = 8'h88;
  localparam logic [7:0] ADDR_IE   = 8'hA8;
  localparam logic [7:0] ADDR_IP   = 8'hB8;
  localparam int SRC_INT0 = 0;
  localparam int SRC_T0   = 1;
  localparam int SRC_INT1 = 2;
  localparam int SRC_T1   = 3;
  localparam int TCON_IT0 = 0;
  localparam int TCON_IE0 = 1;
  localparam int TCON_IT1 = 2;
  localparam int TCON_IE1 = 3;
  localparam int TCON_TF0 = 5;
  localparam int TCON_TF1 = 7;
  localparam int IE_EA    = 7;
  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/int_sync_edge.sv
// int_sync_edge: multi-flop synchronizer for an async pin plus falling-edge pulse
module int_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_sync,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pin};
      r_prev <= r_sync[STAGES-1];
    end
  end
  assign o_sync = r_sync[STAGES-1];
  assign o_fall = r_prev & ~o_sync;
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: 8051-style interrupt controller with TCON/IE/IP, two-level
// priority arbitration and in-service nesting tracking.
module int_ctrl
  import mcu51_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] VEC_BASE    = 8'h03,
  parameter logic [7:0] VEC_STRIDE  = 8'h08
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] int_n,
  input  logic [1:0] timer_ovf,
  input  logic       sfr_wr,
  input  logic [7:0] sfr_addr,
  input  logic [7:0] sfr_wdata,
  output logic [7:0] sfr_rdata,
  output logic       sfr_hit,
  output logic       irq_req,
  output logic [7:0] irq_vector,
  input  logic       irq_ack,
  input  logic       reti
);
  logic [1:0] r_it;
  logic [3:0] r_flag;
  logic       r_ea;
  logic [3:0] r_en;
  logic [3:0] r_ip;
  logic       r_act_hi;
  logic       r_act_lo;
  logic       r_req;
  logic [7:0] r_vec;
  logic [1:0] r_idx;
  logic [1:0] w_sync;
  logic [1:0] w_fall;
  logic       w_is_tcon, w_is_ie, w_is_ip;
  logic       w_wr_tcon, w_wr_ie, w_wr_ip;
  logic [3:0] w_pend, w_elig, w_hi, w_clr;
  logic [3:0] w_hw, w_sw, w_lvl, w_lvl_val, w_edge_nxt, w_flag_nxt;
  logic [1:0] w_win;
  logic       w_take;
  logic [7:0] w_tcon_rd;
  logic       w_unused;
  for (genvar g = 0; g < 2; g++) begin : g_sync
    int_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .i_pin  (int_n[g]),
      .o_sync (w_sync[g]),
      .o_fall (w_fall[g])
    );
  end
  assign w_unused  = ^{sfr_wdata[6], sfr_wdata[4]};
  assign w_is_tcon = sfr_addr == ADDR_TCON;
  assign w_is_ie   = sfr_addr == ADDR_IE;
  assign w_is_ip   = sfr_addr == ADDR_IP;
  assign w_wr_tcon = sfr_wr & w_is_tcon;
  assign w_wr_ie   = sfr_wr & w_is_ie;
  assign w_wr_ip   = sfr_wr & w_is_ip;
  assign w_pend    = r_flag & r_en & {4{r_ea}};
  assign w_elig    = r_act_hi ? 4'b0 : r_act_lo ? (w_pend & r_ip) : w_pend;
  assign w_hi      = w_elig & r_ip;
  assign w_win     = lowest_idx(|w_hi ? w_hi : w_elig);
  assign w_take    = irq_ack & r_req;
  assign w_clr     = w_take ? (4'b0001 << r_idx) : 4'b0;
  always_comb begin
    w_hw = '0;
    w_sw = '0;
    w_lvl = '0;
    w_lvl_val = '0;
    w_tcon_rd = '0;
    w_hw[SRC_INT0] = r_it[0] & w_fall[0];
    w_hw[SRC_T0]   = timer_ovf[0];
    w_hw[SRC_INT1] = r_it[1] & w_fall[1];
    w_hw[SRC_T1]   = timer_ovf[1];
    w_sw[SRC_INT0] = sfr_wdata[TCON_IE0];
    w_sw[SRC_T0]   = sfr_wdata[TCON_TF0];
    w_sw[SRC_INT1] = sfr_wdata[TCON_IE1];
    w_sw[SRC_T1]   = sfr_wdata[TCON_TF1];
    w_lvl[SRC_INT0]     = ~r_it[0];
    w_lvl[SRC_INT1]     = ~r_it[1];
    w_lvl_val[SRC_INT0] = ~w_sync[0];
    w_lvl_val[SRC_INT1] = ~w_sync[1];
    w_tcon_rd[TCON_IT0] = r_it[0];
    w_tcon_rd[TCON_IT1] = r_it[1];
    w_tcon_rd[TCON_IE0] = r_flag[SRC_INT0];
    w_tcon_rd[TCON_TF0] = r_flag[SRC_T0];
    w_tcon_rd[TCON_IE1] = r_flag[SRC_INT1];
    w_tcon_rd[TCON_TF1] = r_flag[SRC_T1];
  end
  // hardware set wins over software/ack clear; level-mode INTx just mirrors the pin
  assign w_edge_nxt = w_hw | (w_wr_tcon ? w_sw : (r_flag & ~w_clr));
  assign w_flag_nxt = (w_lvl & w_lvl_val) | (~w_lvl & w_edge_nxt);
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_it     <= '0;
      r_flag   <= '0;
      r_ea     <= 1'b0;
      r_en     <= '0;
      r_ip     <= '0;
      r_act_hi <= 1'b0;
      r_act_lo <= 1'b0;
      r_req    <= 1'b0;
      r_vec    <= VEC_BASE;
      r_idx    <= '0;
    end else begin
      if (w_wr_tcon) r_it <= {sfr_wdata[TCON_IT1], sfr_wdata[TCON_IT0]};
      r_flag <= w_flag_nxt;
      if (w_wr_ie) {r_ea, r_en} <= {sfr_wdata[IE_EA], sfr_wdata[3:0]};
      if (w_wr_ip) r_ip <= sfr_wdata[3:0];
      // reti retires the highest active level before the ack claims a new one
      r_act_hi <= (w_take & r_ip[r_idx]) | (r_act_hi & ~reti);
      r_act_lo <= (w_take & ~r_ip[r_idx]) | (r_act_lo & ~(reti & ~r_act_hi));
      r_req    <= |w_elig & ~w_take & ~(w_wr_ie | w_wr_ip);
      if (|w_elig) begin
        r_vec <= VEC_BASE + VEC_STRIDE * {6'b0, w_win};
        r_idx <= w_win;
      end
    end
  end
  assign sfr_hit    = w_is_tcon | w_is_ie | w_is_ip;
  assign sfr_rdata  = w_is_tcon ? w_tcon_rd : w_is_ie ? {r_ea, 3'b0, r_en} : w_is_ip ? {4'b0, r_ip} : 8'h00;
  assign irq_req    = r_req;
  assign irq_vector = r_vec;
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed self-checking bench for int_ctrl
module tb_int_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] int_n;
  logic [1:0] timer_ovf;
  logic       sfr_wr;
  logic [7:0] sfr_addr;
  logic [7:0] sfr_wdata;
  logic [7:0] sfr_rdata;
  logic       sfr_hit;
  logic       irq_req;
  logic [7:0] irq_vector;
  logic       irq_ack;
  logic       reti;
  int checks = 0;
  int errors = 0;

  int_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .int_n      (int_n),
    .timer_ovf  (timer_ovf),
    .sfr_wr     (sfr_wr),
    .sfr_addr   (sfr_addr),
    .sfr_wdata  (sfr_wdata),
    .sfr_rdata  (sfr_rdata),
    .sfr_hit    (sfr_hit),
    .irq_req    (irq_req),
    .irq_vector (irq_vector),
    .irq_ack    (irq_ack),
    .reti       (reti)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    sfr_wr = 1'b1;
    sfr_addr = a;
    sfr_wdata = d;
    tick();
    sfr_wr = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    sfr_addr = a;
    #1;
    chk(tag, sfr_rdata, exp);
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic do_reti();
    reti = 1'b1;
    tick();
    reti = 1'b0;
  endtask

  task automatic tmr(input logic [1:0] t);
    timer_ovf = t;
    tick();
    timer_ovf = 2'b00;
  endtask

  initial begin
    reset = 1'b0; int_n = 2'b11; timer_ovf = 2'b00; sfr_wr = 1'b0;
    sfr_addr = 8'h00; sfr_wdata = 8'h00; irq_ack = 1'b0; reti = 1'b0;
    tick(); tick();
    chk("rst_req", {7'b0, irq_req}, 8'h00);
    chk("rst_vec", irq_vector, 8'h03);
    rd("rst_ie", 8'hA8, 8'h00);
    chk("hit_ie", {7'b0, sfr_hit}, 8'h01);
    rd("rd_other", 8'h00, 8'h00);
    chk("hit_other", {7'b0, sfr_hit}, 8'h00);
    reset = 1'b1;
    tick();
    // INT0 edge mode
    wr(8'hA8, 8'h81);
    wr(8'h88, 8'h01);
    int_n[0] = 1'b0;
    tick(); tick(); tick();
    chk("int0_early", {7'b0, irq_req}, 8'h00);
    tick();
    chk("int0_req", {7'b0, irq_req}, 8'h01);
    chk("int0_vec", irq_vector, 8'h03);
    rd("int0_tcon", 8'h88, 8'h03);
    ack();
    chk("int0_ack_req", {7'b0, irq_req}, 8'h00);
    rd("int0_ack_tcon", 8'h88, 8'h01);
    int_n[0] = 1'b1;
    do_reti();
    // T0 + T1 simultaneous, T1 high priority
    wr(8'hA8, 8'h8A);
    wr(8'hB8, 8'h08);
    tmr(2'b11);
    chk("tt_early", {7'b0, irq_req}, 8'h00);
    tick();
    chk("tt_req", {7'b0, irq_req}, 8'h01);
    chk("tt_vec", irq_vector, 8'h1B);
    ack();
    chk("tt_ack_req", {7'b0, irq_req}, 8'h00);
    tick();
    chk("tt_held", {7'b0, irq_req}, 8'h00);
    rd("tt_tcon", 8'h88, 8'h21);
    do_reti();
    chk("tt_reti_req", {7'b0, irq_req}, 8'h00);
    tick();
    chk("t0_req", {7'b0, irq_req}, 8'h01);
    chk("t0_vec", irq_vector, 8'h0B);
    ack();
    chk("t0_ack_req", {7'b0, irq_req}, 8'h00);
    // nesting: T1 high over T0 low in service, INT0 low held
    tmr(2'b10);
    chk("nest_early", {7'b0, irq_req}, 8'h00);
    tick();
    chk("nest_req", {7'b0, irq_req}, 8'h01);
    chk("nest_vec", irq_vector, 8'h1B);
    ack();
    wr(8'hA8, 8'h8B);
    int_n[0] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("nest_int0_held", {7'b0, irq_req}, 8'h00);
    rd("nest_tcon", 8'h88, 8'h03);
    do_reti();
    tick(); tick();
    chk("nest_int0_held2", {7'b0, irq_req}, 8'h00);
    do_reti();
    chk("nest_reti2_req", {7'b0, irq_req}, 8'h00);
    tick();
    chk("nest_int0_req", {7'b0, irq_req}, 8'h01);
    chk("nest_int0_vec", irq_vector, 8'h03);
    ack();
    int_n[0] = 1'b1;
    do_reti();
    // INT1 level mode
    wr(8'hB8, 8'h00);
    wr(8'hA8, 8'h84);
    int_n[1] = 1'b0;
    tick(); tick(); tick();
    chk("lvl_early", {7'b0, irq_req}, 8'h00);
    tick();
    chk("lvl_req", {7'b0, irq_req}, 8'h01);
    chk("lvl_vec", irq_vector, 8'h13);
    ack();
    chk("lvl_ack_req", {7'b0, irq_req}, 8'h00);
    rd("lvl_ack_tcon", 8'h88, 8'h09);
    int_n[1] = 1'b1;
    tick(); tick(); tick();
    rd("lvl_rel_tcon", 8'h88, 8'h01);
    do_reti();
    wr(8'h88, 8'h08);
    tick();
    rd("lvl_sw_ignored", 8'h88, 8'h00);
    chk("lvl_no_req", {7'b0, irq_req}, 8'h00);
    // write blocking
    tmr(2'b01);
    tick();
    chk("blk_disabled", {7'b0, irq_req}, 8'h00);
    wr(8'hA8, 8'h82);
    chk("blk_ie_n1", {7'b0, irq_req}, 8'h00);
    tick();
    chk("blk_ie_n2", {7'b0, irq_req}, 8'h01);
    chk("blk_ie_vec", irq_vector, 8'h0B);
    wr(8'hB8, 8'h02);
    chk("blk_ip_n1", {7'b0, irq_req}, 8'h00);
    tick();
    chk("blk_ip_n2", {7'b0, irq_req}, 8'h01);
    // reset mid-request
    reset = 1'b0;
    tick();
    chk("mrst_req", {7'b0, irq_req}, 8'h00);
    chk("mrst_vec", irq_vector, 8'h03);
    rd("mrst_ie", 8'hA8, 8'h00);
    rd("mrst_ip", 8'hB8, 8'h00);
    rd("mrst_tcon", 8'h88, 8'h00);
    reset = 1'b1;
    tick();
    // hardware set beats software clear
    timer_ovf = 2'b01;
    wr(8'h88, 8'h00);
    timer_ovf = 2'b00;
    rd("hw_beats_sw", 8'h88, 8'h20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
